// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// registered operands, captured result/flags returned over a valid/ready response.
module alu_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int OP_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OP_WIDTH-1:0]  req0_op,
  input  logic [WORD_SIZE-1:0] req0_arg1,
  input  logic [WORD_SIZE-1:0] req0_arg2,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OP_WIDTH-1:0]  req1_op,
  input  logic [WORD_SIZE-1:0] req1_arg1,
  input  logic [WORD_SIZE-1:0] req1_arg2,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [WORD_SIZE-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_pos,
  output logic [OP_WIDTH-1:0]  alu_op,
  output logic [WORD_SIZE-1:0] alu_arg1,
  output logic [WORD_SIZE-1:0] alu_arg2,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_pos,
  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                 r_state, w_next;
  logic                   r_last_grant;
  logic                   r_owner;
  logic [OP_WIDTH-1:0]    r_alu_op;
  logic [WORD_SIZE-1:0]   r_alu_arg1, r_alu_arg2;
  logic [WORD_SIZE-1:0]   r_rsp_result;
  logic                   r_rsp_zero, r_rsp_pos;
  logic                   w_idle, w_req_hs, w_rsp_hs;

  assign w_idle = (r_state == IDLE);

  // Contention goes to whoever did not win last; an uncontested request always wins.
  assign req0_ready = w_idle & req0_valid & (~req1_valid | r_last_grant);
  assign req1_ready = w_idle & req1_valid & (~req0_valid | ~r_last_grant);
  assign w_req_hs   = req0_ready | req1_ready;

  assign rsp0_valid = (r_state == RESP) & ~r_owner;
  assign rsp1_valid = (r_state == RESP) &  r_owner;
  assign w_rsp_hs   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req_hs) w_next = ISSUE;
      ISSUE:   w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_op     <= '0;
      r_alu_arg1   <= '0;
      r_alu_arg2   <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_pos    <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_owner      <= req1_ready;
        r_last_grant <= req1_ready;
        r_alu_op     <= req1_ready ? req1_op   : req0_op;
        r_alu_arg1   <= req1_ready ? req1_arg1 : req0_arg1;
        r_alu_arg2   <= req1_ready ? req1_arg2 : req0_arg2;
      end
      if (r_state == ISSUE) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rsp_pos    <= alu_pos;
      end
    end
  end

  assign alu_op     = r_alu_op;
  assign alu_arg1   = r_alu_arg1;
  assign alu_arg2   = r_alu_arg2;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_pos    = r_rsp_pos;
  assign busy       = ~w_idle;
  assign owner      = r_owner;

endmodule
